// File: rtl/sl_tx_fifo.sv
// SL-line transmitter: register-mapped word FIFO feeding a phase-timed frame FSM
// (start, N data bits with gaps, parity, stop) on a differential sl0/sl1 pair.
module sl_tx_fifo #(
  parameter int MAX_BITS   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  addr,
  input  logic        wr_en,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        sl0,
  output logic        sl1,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [5:0]       MAX_N    = 6'(MAX_BITS);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_PGAP   = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;
  localparam logic [2:0] ST_END    = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [DIV_W-1:0]    phase_q, phase_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [MAX_BITS-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                sl0_q, sl0_d;
  logic                sl1_q, sl1_d;
  logic                irq_q, irq_d;
  logic [31:0]         last_word_q, last_word_d;

  logic [5:0]          cfg_n_q, cfg_n_d;
  logic                cfg_irq_en_q, cfg_irq_en_d;
  logic                cfg_par_even_q, cfg_par_even_d;
  logic [DIV_W-1:0]    cfg_div_q, cfg_div_d;

  logic                ovf_q, ovf_d;
  logic                cfg_err_q, cfg_err_d;
  logic                done_q, done_d;

  logic [31:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  logic                fifo_empty, fifo_full;
  logic                wr_data, wr_cfg, wr_stat;
  logic                push, pop, start_frame, done_set, ovf_set;
  logic                phase_end, cfg_ok, parity_bit;
  logic [5:0]          new_n;
  logic [DIV_W-1:0]    new_div;
  logic [31:0]         head;
  logic [31:0]         cfg_rd, stat_rd;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign wr_data    = wr_en && (addr == 2'd0);
  assign wr_cfg     = wr_en && (addr == 2'd1);
  assign wr_stat    = wr_en && (addr == 2'd2);
  assign phase_end  = (phase_q == cfg_div_q);
  assign head       = mem[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign push    = wr_data && (!fifo_full || pop);
  assign ovf_set = wr_data && fifo_full && !pop;

  assign new_n   = d_in[5:0];
  assign new_div = d_in[8 +: DIV_W];
  assign cfg_ok  = !new_n[0] && (new_n >= 6'd8) && (new_n <= MAX_N) &&
                   (new_div != '0) && (state_q == ST_IDLE) && fifo_empty;

  // Frame sequencer
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q + DIV_W'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    last_word_d = last_word_q;
    pop         = 1'b0;
    start_frame = 1'b0;
    done_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (!fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        if (phase_end) begin
          state_d = ST_DATA;
          phase_d = '0;
        end
      end
      ST_DATA: begin
        if (phase_end) begin
          state_d   = ST_GAP;
          phase_d   = '0;
          shift_d   = shift_q >> 1;
          par_d     = par_q ^ shift_q[0];
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      ST_GAP: begin
        if (phase_end) begin
          state_d = (bit_cnt_q == cfg_n_q) ? ST_PARITY : ST_DATA;
          phase_d = '0;
        end
      end
      ST_PARITY: begin
        if (phase_end) begin
          state_d = ST_PGAP;
          phase_d = '0;
        end
      end
      ST_PGAP: begin
        if (phase_end) begin
          state_d = ST_STOP;
          phase_d = '0;
        end
      end
      ST_STOP: begin
        if (phase_end) begin
          state_d = ST_END;
          phase_d = '0;
        end
      end
      ST_END: begin
        if (phase_end) begin
          done_set = 1'b1;
          phase_d  = '0;
          if (!fifo_empty) start_frame = 1'b1;
          else             state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase

    if (start_frame) begin
      state_d     = ST_START;
      phase_d     = '0;
      pop         = 1'b1;
      shift_d     = head[MAX_BITS-1:0];
      last_word_d = head;
      bit_cnt_d   = '0;
      par_d       = 1'b0;
    end
  end

  // Lines are decoded from the next state so they switch on the same edge as the FSM.
  assign parity_bit = par_d ^ ~cfg_par_even_q;

  always_comb begin
    sl0_d = 1'b1;
    sl1_d = 1'b1;
    case (state_d)
      ST_DATA: begin
        sl0_d = shift_d[0];
        sl1_d = ~shift_d[0];
      end
      ST_PARITY: begin
        sl0_d = parity_bit;
        sl1_d = ~parity_bit;
      end
      ST_STOP: begin
        sl0_d = 1'b0;
        sl1_d = 1'b0;
      end
      default: begin
        sl0_d = 1'b1;
        sl1_d = 1'b1;
      end
    endcase
  end

  // Register file: CONFIG load/reject and sticky status flags (set beats clear)
  always_comb begin
    cfg_n_d        = cfg_n_q;
    cfg_irq_en_d   = cfg_irq_en_q;
    cfg_par_even_d = cfg_par_even_q;
    cfg_div_d      = cfg_div_q;
    cfg_err_d      = cfg_err_q;
    ovf_d          = ovf_q;
    done_d         = done_q;

    if (wr_stat && d_in[3]) ovf_d     = 1'b0;
    if (wr_stat && d_in[4]) cfg_err_d = 1'b0;
    if (wr_stat && d_in[5]) done_d    = 1'b0;

    if (wr_cfg) begin
      if (cfg_ok) begin
        cfg_n_d        = new_n;
        cfg_irq_en_d   = d_in[6];
        cfg_par_even_d = d_in[7];
        cfg_div_d      = new_div;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (ovf_set)  ovf_d  = 1'b1;
    if (done_set) done_d = 1'b1;

    irq_d = cfg_irq_en_d & done_d;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= d_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      phase_q        <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      par_q          <= 1'b0;
      sl0_q          <= 1'b1;
      sl1_q          <= 1'b1;
      irq_q          <= 1'b0;
      last_word_q    <= '0;
      cfg_n_q        <= 6'd8;
      cfg_irq_en_q   <= 1'b0;
      cfg_par_even_q <= 1'b0;
      cfg_div_q      <= DIV_RST;
      ovf_q          <= 1'b0;
      cfg_err_q      <= 1'b0;
      done_q         <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      par_q          <= par_d;
      sl0_q          <= sl0_d;
      sl1_q          <= sl1_d;
      irq_q          <= irq_d;
      last_word_q    <= last_word_d;
      cfg_n_q        <= cfg_n_d;
      cfg_irq_en_q   <= cfg_irq_en_d;
      cfg_par_even_q <= cfg_par_even_d;
      cfg_div_q      <= cfg_div_d;
      ovf_q          <= ovf_d;
      cfg_err_q      <= cfg_err_d;
      done_q         <= done_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  assign cfg_rd  = {{(24-DIV_W){1'b0}}, cfg_div_q, cfg_par_even_q, cfg_irq_en_q, cfg_n_q};
  assign stat_rd = {16'd0, 8'(count_q), 2'b00, done_q, cfg_err_q, ovf_q,
                    fifo_full, fifo_empty, (state_q != ST_IDLE)};

  always_comb begin
    case (addr)
      2'd0:    d_out = last_word_q;
      2'd1:    d_out = cfg_rd;
      2'd2:    d_out = stat_rd;
      default: d_out = 32'd0;
    endcase
  end

  assign sl0 = sl0_q;
  assign sl1 = sl1_q;
  assign irq = irq_q;

endmodule
